// File: rtl/note_pkg.sv
// Constants and types shared by the note feed buffer and its FIFO.
package note_pkg;

    localparam int BASE_POS  = 20;
    localparam int STEP_LOG2 = 2;
    localparam int NUM_LANES = 5;

    typedef struct packed {
        logic [2:0] lane;
        logic [7:0] seq;
    } note_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/note_fifo.sv
// First-word-fall-through FIFO of note_t entries with flush; head is read combinationally.
module note_fifo
    import note_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  note_t                    din,
    input  logic                     pop,
    input  logic                     flush,
    output note_t                    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    note_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pop_ok;
    logic               push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty && !flush;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = push && (!full || pop_ok) && !flush;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/note_feed_buffer.sv
// Samples the note generator on beat ticks, converts positions to lanes and queues
// them for the renderer behind a valid/ready handshake.
module note_feed_buffer
    import note_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     flush,
    input  logic                     beat_tick,
    input  logic                     gen_en,
    input  logic [7:0]               gen_data,
    output logic                     note_valid,
    output logic [2:0]               note_lane,
    output logic [7:0]               note_seq,
    input  logic                     note_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     running,
    output logic [7:0]               overflow_cnt,
    output logic [7:0]               invalid_cnt
);

    state_t      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  ovf_q, ovf_d;
    logic [7:0]  inv_q, inv_d;

    logic        capture;
    logic [8:0]  off;
    logic [8:0]  lane_idx;
    logic        pos_ok;
    logic        push_req;
    logic        pop_req;
    logic        fifo_full;
    logic        fifo_empty;
    note_t       push_note;
    note_t       head;

    // Flush discards same-cycle activity, so it also suppresses capture.
    assign capture  = (state_q == ST_RUN) && !pause && beat_tick && gen_en && !flush;
    assign off      = {1'b0, gen_data} - 9'(BASE_POS);
    assign lane_idx = off >> STEP_LOG2;
    assign pos_ok   = (gen_data >= 8'(BASE_POS))
                   && (off[STEP_LOG2-1:0] == '0)
                   && (lane_idx < 9'(NUM_LANES));
    assign push_req = capture && pos_ok;
    assign pop_req  = note_valid && note_ready;

    assign push_note.lane = lane_idx[2:0];
    assign push_note.seq  = seq_q;

    note_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .din    (push_note),
        .pop    (pop_req),
        .flush  (flush),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Head fields read as zero while empty so stale RAM contents never show.
    assign note_valid   = !fifo_empty;
    assign note_lane    = note_valid ? head.lane : 3'd0;
    assign note_seq     = note_valid ? head.seq  : 8'd0;
    assign running      = (state_q == ST_RUN);
    assign overflow_cnt = ovf_q;
    assign invalid_cnt  = inv_q;

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        ovf_d   = ovf_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: if (start && !flush) state_d = ST_RUN;
            ST_RUN:  if (flush)           state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
        if (capture && !pos_ok && inv_q != 8'hFF) inv_d = inv_q + 8'd1;
        // Seq advances even on overflow so the renderer can see the gap.
        if (push_req) begin
            seq_d = seq_q + 8'd1;
            if (fifo_full && !pop_req && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            seq_q   <= 8'd0;
            ovf_q   <= 8'd0;
            inv_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            inv_q   <= inv_d;
        end
    end

endmodule

// File: tb/tb_note_feed_buffer.sv
// Directed bench for note_feed_buffer: handshake, overflow, validation, pause, flush, reset.
module tb_note_feed_buffer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start, pause, flush, beat_tick, gen_en;
    logic [7:0] gen_data;
    logic       note_valid;
    logic [2:0] note_lane;
    logic [7:0] note_seq;
    logic       note_ready;
    logic [3:0] fifo_count;
    logic       running;
    logic [7:0] overflow_cnt;
    logic [7:0] invalid_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    note_feed_buffer #(.DEPTH(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .pause        (pause),
        .flush        (flush),
        .beat_tick    (beat_tick),
        .gen_en       (gen_en),
        .gen_data     (gen_data),
        .note_valid   (note_valid),
        .note_lane    (note_lane),
        .note_seq     (note_seq),
        .note_ready   (note_ready),
        .fifo_count   (fifo_count),
        .running      (running),
        .overflow_cnt (overflow_cnt),
        .invalid_cnt  (invalid_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(note_valid), 0);
        chk({tag, "_lane"},  32'(note_lane), 0);
        chk({tag, "_seq"},   32'(note_seq), 0);
        chk({tag, "_count"}, 32'(fifo_count), 0);
        chk({tag, "_run"},   32'(running), 0);
        chk({tag, "_ovf"},   32'(overflow_cnt), 0);
        chk({tag, "_inv"},   32'(invalid_cnt), 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0; start = 0; pause = 0; flush = 0;
        beat_tick = 0; gen_en = 0; gen_data = 8'd0; note_ready = 0;
        step();
        step();
        check_zero("rst");
        resetn = 1'b1;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One-cycle beat tick with gen_en high.
    task automatic tick(input logic [7:0] pos);
        gen_en = 1'b1; gen_data = pos; beat_tick = 1'b1;
        step();
        beat_tick = 1'b0;
    endtask

    initial begin
        // 1: basic stream, one cycle latency, immediate consumption
        do_reset();
        do_start();
        chk("t1_running", 32'(running), 1);
        note_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(8'(20 + 4 * i));
            chk($sformatf("t1_valid%0d", i), 32'(note_valid), 1);
            chk($sformatf("t1_lane%0d", i),  32'(note_lane), 32'(i));
            chk($sformatf("t1_seq%0d", i),   32'(note_seq), 32'(i));
            step();
            chk($sformatf("t1_popped%0d", i), 32'(note_valid), 0);
        end
        chk("t1_ovf", 32'(overflow_cnt), 0);
        chk("t1_inv", 32'(invalid_cnt), 0);

        // 2: fill to overflow with renderer stalled, then drain in order
        do_reset();
        do_start();
        note_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick(8'(20 + 4 * (i % 5)));
        chk("t2_count", 32'(fifo_count), 8);
        chk("t2_ovf",   32'(overflow_cnt), 2);
        chk("t2_head_seq", 32'(note_seq), 0);
        step();
        step();
        chk("t2_stall_seq",  32'(note_seq), 0);
        chk("t2_stall_lane", 32'(note_lane), 0);
        note_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_drain_seq%0d", i),  32'(note_seq), 32'(i));
            chk($sformatf("t2_drain_lane%0d", i), 32'(note_lane), 32'(i % 5));
            step();
        end
        chk("t2_empty", 32'(note_valid), 0);
        chk("t2_count0", 32'(fifo_count), 0);

        // 3: invalid positions: misaligned, past last lane, below base
        do_reset();
        do_start();
        note_ready = 1'b0;
        tick(8'd22);
        tick(8'd40);
        tick(8'd19);
        chk("t3_count", 32'(fifo_count), 0);
        chk("t3_inv",   32'(invalid_cnt), 3);
        tick(8'd24);
        chk("t3_lane", 32'(note_lane), 1);
        chk("t3_seq",  32'(note_seq), 0);

        // 4: pause suppresses capture; IDLE suppresses capture
        do_reset();
        do_start();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) tick(8'd20);
        chk("t4_paused_count", 32'(fifo_count), 0);
        chk("t4_paused_run",   32'(running), 1);
        pause = 1'b0;
        tick(8'd28);
        chk("t4_count", 32'(fifo_count), 1);
        chk("t4_lane",  32'(note_lane), 2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_idle", 32'(running), 0);
        tick(8'd20);
        tick(8'd24);
        chk("t4_idle_count", 32'(fifo_count), 0);
        chk("t4_idle_valid", 32'(note_valid), 0);

        // 5: full FIFO with simultaneous push and pop
        do_reset();
        do_start();
        note_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick(8'(20 + 4 * (i % 5)));
        chk("t5_full", 32'(fifo_count), 8);
        note_ready = 1'b1;
        tick(8'd36);
        note_ready = 1'b0;
        chk("t5_count", 32'(fifo_count), 8);
        chk("t5_ovf",   32'(overflow_cnt), 0);
        chk("t5_head",  32'(note_seq), 1);

        // 6: flush beats start; counters and seq survive flush
        do_reset();
        do_start();
        note_ready = 1'b0;
        tick(8'd21);
        for (int i = 0; i < 3; i++) tick(8'd20);
        chk("t6_count", 32'(fifo_count), 3);
        flush = 1'b1; start = 1'b1;
        step();
        flush = 1'b0; start = 1'b0;
        chk("t6_run",   32'(running), 0);
        chk("t6_count0", 32'(fifo_count), 0);
        chk("t6_valid", 32'(note_valid), 0);
        chk("t6_inv",   32'(invalid_cnt), 1);
        do_start();
        tick(8'd32);
        chk("t6_seq",  32'(note_seq), 3);
        chk("t6_lane", 32'(note_lane), 3);

        // 7: asynchronous reset mid-stream
        tick(8'd24);
        tick(8'd40);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check_zero("t7");
        step();
        resetn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_feed_buffer.md
Name: note_feed_buffer

Overview:
- Sits directly downstream of the beatmap note generator, which presents a free-running (gen_en, gen_data[7:0]) stream of note x-positions.
- Samples that stream once per beat tick, validates the position and converts it to a lane index.
- Stores converted notes in a small first-word-fall-through FIFO.
- Delivers notes to the falling-note renderer over a valid/ready handshake, with run/pause/flush control and error counters.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- BASE_POS, 20: gen_data value mapped to lane 0.
- STEP_LOG2, 2: log2 of the position spacing between lanes (spacing 4).
- NUM_LANES, 5: number of valid lanes; lane = (gen_data-BASE_POS)>>STEP_LOG2.

Ports:
- clk, in, 1: system clock.
- resetn, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse; IDLE->RUN.
- pause, in, 1: level; while high in RUN, beat ticks are ignored.
- flush, in, 1: one-cycle pulse; empties the FIFO and returns to IDLE.
- beat_tick, in, 1: one-cycle pulse from the tempo divider.
- gen_en, in, 1: generator data-valid.
- gen_data, in, 8: generator note position.
- note_valid, out, 1: FIFO head valid.
- note_lane, out, 3: lane of the FIFO head.
- note_seq, out, 8: sequence number of the FIFO head.
- note_ready, in, 1: renderer accepts the head this cycle.
- fifo_count, out, $clog2(DEPTH)+1: current occupancy.
- running, out, 1: high in RUN state, including while paused.
- overflow_cnt, out, 8: notes dropped because the FIFO was full; saturates at 255.
- invalid_cnt, out, 8: notes dropped because the position was invalid; saturates at 255.

Behaviour:
- Reset (async, resetn=0): state IDLE, FIFO empty, note_valid=0, note_lane=0, note_seq=0, fifo_count=0, running=0, both counters 0, internal seq counter 0. Reset asserted mid-operation discards all contents immediately.
- States:
  - IDLE: start -> RUN.
  - RUN: flush -> IDLE. start while already in RUN is ignored.
  - flush has priority over start in the same cycle.
- Capture: a note is captured on a clk edge where state==RUN && !pause && beat_tick && gen_en. It is not captured in IDLE, while paused, or when gen_en=0.
- Validation, width rules:
  - off = gen_data - BASE_POS, computed in 9 bits.
  - Valid iff gen_data >= BASE_POS, the low STEP_LOG2 bits of off are 0, and (off>>STEP_LOG2) < NUM_LANES.
  - Invalid notes are dropped: invalid_cnt++ (saturating). The FIFO and the seq counter are unchanged.
- Push: a valid note writes {lane[2:0], seq[7:0]} into the FIFO. seq then increments and wraps 255->0.
- Full FIFO:
  - A push with no pop drops the note: overflow_cnt++ (saturating). seq still increments, so the renderer can detect the gap.
  - A push with a pop in the same cycle both succeed; count is unchanged.
- Latency: a note captured at edge N is visible at the outputs (note_valid=1, head fields) after edge N when the FIFO was empty, i.e. one cycle after the capture edge.
- Output handshake:
  - Pop occurs when note_valid && note_ready.
  - note_lane/note_seq must hold stable while note_valid && !note_ready.
  - When the FIFO is empty, note_valid=0 and note_ready is ignored.
- Simultaneous push and pop on an empty FIFO is impossible, because note_valid=0. The push lands; the pop does not occur.
- fifo_count updates on the same edge as push/pop.
- Flush:
  - Empties the FIFO (pointers, count) on that edge; note_valid=0 on the next cycle.
  - Any push or pop in the same cycle is discarded.
  - Counters and seq are preserved; they clear only on reset.
- Pointers: $clog2(DEPTH) bits, natural wrap.

Decomposition:
- Shared package (note_pkg):
  - BASE_POS, STEP_LOG2, NUM_LANES constants.
  - typedef note_t {lane[2:0], seq[7:0]}.
  - State enum {IDLE, RUN}.
- One sub-module, note_fifo: a parameterised FWFT synchronous FIFO with push/pop/flush, full/empty/count.
- The top level holds the FSM, capture/validation, seq counter and saturating counters.

Test Plan:
- Reset, then start; stream 20,24,28,32,36 with gen_en=1, one beat_tick per value, note_ready=1 -> lanes 0,1,2,3,4 emitted with seq 0..4, each note_valid one cycle after its tick; counters 0.
- note_ready=0; 10 valid ticks into DEPTH=8 -> fifo_count=8, overflow_cnt=2. Then drain -> seq 0..7 in order, with the head stable while stalled.
- Ticks with gen_data=22, 40, 19 -> nothing pushed, invalid_cnt=3. Next valid note carries seq=0.
- pause=1 for 3 ticks, then pause=0 for 1 tick with gen_data=28 -> exactly one note (lane 2) pushed. Ticks in IDLE push nothing.
- FIFO full (8 entries) with a tick and note_ready=1 in the same cycle -> pop and push both occur, fifo_count stays 8, overflow_cnt unchanged.
- 3 entries, then flush and start pulsed together -> IDLE, fifo_count=0, note_valid=0, counters retained. Separately, assert resetn=0 mid-stream -> all outputs 0 asynchronously.
